controle_rodadas_jogo: RTL and testbench
========================================

// Module: controle_rodadas_jogo
// PURPOSE
//  Moore FSM that sequences the memory-game datapath across rounds. Round N (N = 0..last) plays
//  moves 0..N; each move is registered, compared to memory and must arrive before a timeout.
//  Sits between the top level and the datapath (address counter E, round-limit counter L,
//  move register R); owns the per-move timeout counter and the move edge detector.
// PARAMETERS
//  TIMEOUT   5000  cycles allowed in espera_jogada per move (5 s at 1 kHz)
//  TW        13    width of internal timeout counter; must satisfy 2**TW > TIMEOUT
// PORTS
//  clock      in   1  system clock, rising edge
//  reset      in   1  asynchronous, active-high; forces state inicial
//  iniciar    in   1  start/restart request, level
//  jogada     in   1  OR of player buttons, level (already synchronised)
//  igual      in   1  datapath: registered move == memory[E]
//  fimE       in   1  datapath: E == L (last move of current round)
//  fimL       in   1  datapath: L == last round
//  zeraE      out  1  clear address counter
//  contaE     out  1  increment address counter
//  zeraL      out  1  clear round-limit counter
//  contaL     out  1  increment round-limit counter
//  zeraR      out  1  clear move register
//  registraR  out  1  load move register
//  pronto     out  1  game finished (any final state)
//  ganhou     out  1  all rounds completed
//  perdeu     out  1  wrong move or timeout
//  timeout    out  1  finished because of timeout
//  db_estado  out  4  current state code (debug)
// BEHAVIOUR
//  Reset: always enters inicial (also mid-round); timeout counter = 0, edge-detector history = 0.
//  All outputs are decoded from the state only (Moore).
//  States/codes: inicial 0, preparacao 1, inicia_rodada 2, espera_jogada 3, registra 4,
//   compara 5, proxima_jogada 6, proxima_rodada 7, final_acertou C, final_errou D, final_timeout E.
//  Outputs by state: inicial, preparacao -> zeraE, zeraL, zeraR; inicia_rodada -> zeraE, zeraR;
//   registra -> registraR; proxima_jogada -> contaE; proxima_rodada -> contaL;
//   C -> pronto, ganhou; D -> pronto, perdeu; E -> pronto, perdeu, timeout. All others 0.
//  After reset: zeraE = zeraL = zeraR = 1, every other output 0, db_estado = 0.
//  Transitions:
//   inicial: iniciar ? preparacao : inicial
//   preparacao -> inicia_rodada -> espera_jogada (unconditional, one cycle each)
//   espera_jogada: move edge ? registra : (tcount == TIMEOUT-1 ? final_timeout : stay)
//   registra -> compara
//   compara: !igual -> final_errou; igual & !fimE -> proxima_jogada;
//            igual & fimE & fimL -> final_acertou; igual & fimE & !fimL -> proxima_rodada
//   proxima_jogada -> espera_jogada;  proxima_rodada -> inicia_rodada
//   C, D, E: iniciar ? preparacao : stay.  Unused codes -> inicial; db_estado = F there.
//  Move edge: jogada rising edge (jogada & ~jogada_d1); a held button yields exactly one move.
//  Timeout counter: cleared whenever state != espera_jogada, increments every cycle in it;
//   so every move window is exactly TIMEOUT cycles. Edge and expiry in same cycle: edge wins.
//  Latency: move edge -> compara = 2 cycles; compara -> next espera_jogada = 2 cycles.
//  iniciar ignored in all non-final states except inicial.
// STRUCTURE
//  Shared package/include: the 4-bit state-code constants (also decoded by the 7-seg debug display).
//  One sub-module: edge_detector (clock, reset, sinal, pulso); timeout counter kept inline.
// TESTING
//  1 reset mid-round (in state 3) -> next cycle db_estado=0, zeraE=zeraL=zeraR=1, pronto=0
//  2 TIMEOUT=8, 4 rounds (fimL at L=3), all igual=1 -> visits 2,3,4,5 per move, 7 between
//    rounds; 10 moves total; ends in C, ganhou=pronto=1; iniciar -> state 1
//  3 round 1, move 1 with igual=0 -> compara goes to D: perdeu=1, ganhou=0, timeout=0
//  4 no move for 8 cycles in espera_jogada -> state E on cycle 9, timeout=perdeu=pronto=1
//  5 edge in the same cycle tcount=7 -> state 4, not E; next window restarts at tcount=0
//  6 jogada held high 20 cycles -> exactly one registraR pulse; second move needs release

Source files
------------

// File: rtl/controle_rodadas_jogo_pkg.sv
// Shared definitions for the memory-game round controller.
// The 4-bit state codes are also decoded by the 7-segment debug display,
// so their numeric values are part of the interface.
package controle_rodadas_jogo_pkg;

  typedef enum logic [3:0] {
    inicial        = 4'h0,
    preparacao     = 4'h1,
    inicia_rodada  = 4'h2,
    espera_jogada  = 4'h3,
    registra       = 4'h4,
    compara        = 4'h5,
    proxima_jogada = 4'h6,
    proxima_rodada = 4'h7,
    final_acertou  = 4'hC,
    final_errou    = 4'hD,
    final_timeout  = 4'hE
  } estado_t;

  // Reported on db_estado when the state register holds an unused code.
  localparam logic [3:0] ESTADO_INVALIDO = 4'hF;

endpackage

// File: rtl/controle_rodadas_jogo_edge_detector.sv
// Rising-edge detector for an already-synchronised level input.
//  clock  in  system clock, rising edge
//  reset  in  asynchronous, active-high; clears the history bit
//  sinal  in  level input
//  pulso  out one-cycle pulse when sinal goes 0 -> 1
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic sinal_d1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sinal_d1 <= 1'b0;
    else       sinal_d1 <= sinal;
  end

  assign pulso = sinal & ~sinal_d1;

endmodule

// File: rtl/controle_rodadas_jogo.sv
// Moore FSM sequencing the memory-game datapath across rounds.
// Round N plays moves 0..N; each move is registered, compared to memory
// and must arrive within TIMEOUT cycles of entering espera_jogada.
//  clock, reset                 rising-edge clock; async active-high reset
//  iniciar                      start/restart request (level)
//  jogada                       OR of player buttons (level, synchronised)
//  igual, fimE, fimL            datapath status flags
//  zeraE/contaE, zeraL/contaL   address / round-limit counter controls
//  zeraR/registraR              move register controls
//  pronto, ganhou, perdeu,      game-end status
//  timeout
//  db_estado                    current state code (debug)
module controle_rodadas_jogo
  import controle_rodadas_jogo_pkg::*;
#(
  parameter int unsigned TIMEOUT = 5000,
  parameter int unsigned TW      = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t       estado, proximo;
  logic [TW-1:0] tcount;
  logic          jogada_pulso;
  logic          expirou;

  edge_detector u_edge_jogada (
    .clock (clock),
    .reset (reset),
    .sinal (jogada),
    .pulso (jogada_pulso)
  );

  // Counter restarts on every exit from espera_jogada, so each move window
  // is exactly TIMEOUT cycles long.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        tcount <= '0;
    else if (estado != espera_jogada) tcount <= '0;
    else                              tcount <= tcount + 1'b1;
  end

  assign expirou = (tcount == TW'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= inicial;
    else       estado <= proximo;
  end

  always_comb begin
    proximo = inicial;
    case (estado)
      inicial:        proximo = iniciar ? preparacao : inicial;
      preparacao:     proximo = inicia_rodada;
      inicia_rodada:  proximo = espera_jogada;
      // A move arriving on the expiry cycle still counts.
      espera_jogada:  proximo = jogada_pulso ? registra :
                                expirou      ? final_timeout : espera_jogada;
      registra:       proximo = compara;
      compara: begin
        if (!igual)     proximo = final_errou;
        else if (!fimE) proximo = proxima_jogada;
        else if (fimL)  proximo = final_acertou;
        else            proximo = proxima_rodada;
      end
      proxima_jogada: proximo = espera_jogada;
      proxima_rodada: proximo = inicia_rodada;
      final_acertou:  proximo = iniciar ? preparacao : final_acertou;
      final_errou:    proximo = iniciar ? preparacao : final_errou;
      final_timeout:  proximo = iniciar ? preparacao : final_timeout;
      default:        proximo = inicial;
    endcase
  end

  always_comb begin
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraL     = 1'b0;
    contaL    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    ganhou    = 1'b0;
    perdeu    = 1'b0;
    timeout   = 1'b0;
    db_estado = estado;
    case (estado)
      inicial, preparacao: begin
        zeraE = 1'b1;
        zeraL = 1'b1;
        zeraR = 1'b1;
      end
      inicia_rodada: begin
        zeraE = 1'b1;
        zeraR = 1'b1;
      end
      espera_jogada, compara: ;
      registra:       registraR = 1'b1;
      proxima_jogada: contaE    = 1'b1;
      proxima_rodada: contaL    = 1'b1;
      final_acertou: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      final_errou: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      final_timeout: begin
        pronto  = 1'b1;
        perdeu  = 1'b1;
        timeout = 1'b1;
      end
      default: db_estado = ESTADO_INVALIDO;
    endcase
  end

endmodule

// File: tb/tb_controle_rodadas_jogo.sv
// Directed bench for controle_rodadas_jogo with TIMEOUT=8, four rounds.
// A small datapath model (E and L counters) answers fimE/fimL from the
// DUT's counter controls; igual is driven directly.
module tb_controle_rodadas_jogo;

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada, igual, fimE, fimL;
  logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic       pronto, ganhou, perdeu, timeout;
  logic [3:0] db_estado;
  logic [3:0] end_e, lim_l;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_pulsos;

  always #5 clock = ~clock;

  controle_rodadas_jogo #(.TIMEOUT(8), .TW(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogada    (jogada),
    .igual     (igual),
    .fimE      (fimE),
    .fimL      (fimL),
    .zeraE     (zeraE),
    .contaE    (contaE),
    .zeraL     (zeraL),
    .contaL    (contaL),
    .zeraR     (zeraR),
    .registraR (registraR),
    .pronto    (pronto),
    .ganhou    (ganhou),
    .perdeu    (perdeu),
    .timeout   (timeout),
    .db_estado (db_estado)
  );

  // Datapath model: last round is L == 3.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      end_e <= '0;
      lim_l <= '0;
    end else begin
      if (zeraE)       end_e <= '0;
      else if (contaE) end_e <= end_e + 4'd1;
      if (zeraL)       lim_l <= '0;
      else if (contaL) lim_l <= lim_l + 4'd1;
    end
  end

  assign fimE = (end_e == lim_l);
  assign fimL = (lim_l == 4'd3);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  // From espera_jogada: pulse one move, check registra then compara.
  task automatic play_move();
    jogada = 1'b1;
    step();
    check("registra", db_estado, 4'h4);
    check("registraR", registraR, 1'b1);
    jogada = 1'b0;
    step();
    check("compara", db_estado, 4'h5);
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    step();
    check("start_prep", db_estado, 4'h1);
    iniciar = 1'b0;
    step();
    check("start_inicia", db_estado, 4'h2);
    step();
    check("start_espera", db_estado, 4'h3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b1;
    step(); step();
    check("rst_estado", db_estado, 4'h0);
    check("rst_zeras", {zeraE, zeraL, zeraR}, 3'b111);
    check("rst_others", {contaE, contaL, registraR, pronto, ganhou, perdeu, timeout}, 7'b0);
    reset = 1'b0;
    step();
    check("inicial_holds", db_estado, 4'h0);

    // 1: reset in the middle of a round
    start_game();
    reset = 1'b1;
    step();
    check("midrst_estado", db_estado, 4'h0);
    check("midrst_zeras", {zeraE, zeraL, zeraR}, 3'b111);
    check("midrst_pronto", pronto, 1'b0);
    reset = 1'b0;
    step();

    // 2: full winning game, 4 rounds, 10 moves
    start_game();
    for (int r = 0; r < 4; r++) begin
      for (int m = 0; m <= r; m++) begin
        check("win_espera", db_estado, 4'h3);
        play_move();
        step();
        if (m < r) begin
          check("win_prox_jog", db_estado, 4'h6);
          check("win_contaE", contaE, 1'b1);
          step();
        end else if (r < 3) begin
          check("win_prox_rod", db_estado, 4'h7);
          check("win_contaL", contaL, 1'b1);
          step();
          check("win_inicia", db_estado, 4'h2);
          step();
        end else begin
          check("win_final", db_estado, 4'hC);
        end
      end
    end
    check("win_flags", {pronto, ganhou, perdeu, timeout}, 4'b1100);
    step();
    check("win_stays", db_estado, 4'hC);

    // 3: wrong second move of round 1
    start_game();
    play_move();
    step();
    check("err_r0_prox_rod", db_estado, 4'h7);
    step(); step();
    check("err_r1_espera", db_estado, 4'h3);
    play_move();
    step();
    check("err_r1_prox_jog", db_estado, 4'h6);
    step();
    igual = 1'b0;
    play_move();
    step();
    check("err_final", db_estado, 4'hD);
    check("err_flags", {pronto, ganhou, perdeu, timeout}, 4'b1010);
    igual = 1'b1;

    // 4: no move for 8 cycles -> timeout; iniciar ignored while waiting
    start_game();
    iniciar = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step();
      check("to_wait", db_estado, 4'h3);
    end
    iniciar = 1'b0;
    step();
    check("to_final", db_estado, 4'hE);
    check("to_flags", {pronto, ganhou, perdeu, timeout}, 4'b1011);

    // 5: edge on the expiry cycle wins; next window starts from zero
    start_game();
    repeat (7) step();
    check("edge_last_wait", db_estado, 4'h3);
    jogada = 1'b1;
    step();
    check("edge_wins", db_estado, 4'h4);
    jogada = 1'b0;
    step(); step(); step(); step();
    check("edge_new_window", db_estado, 4'h3);
    for (int i = 1; i < 8; i++) begin
      step();
      check("edge_rewait", db_estado, 4'h3);
    end
    step();
    check("edge_rewait_to", db_estado, 4'hE);

    // 6: held button gives exactly one move
    start_game();
    jogada = 1'b1;
    n_pulsos = 0;
    repeat (20) begin
      step();
      if (registraR) n_pulsos++;
    end
    check("hold_pulses", n_pulsos, 1);
    check("hold_timeout", db_estado, 4'hE);
    start_game();
    step();
    check("hold_no_move", db_estado, 4'h3);
    jogada = 1'b0;
    step();
    check("release_wait", db_estado, 4'h3);
    jogada = 1'b1;
    step();
    check("second_move", db_estado, 4'h4);
    jogada = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
